// File: rtl/relu_backward_pkg.sv
// Shared defaults and FSM state encoding for the ReLU backward (gradient mask) unit.
package relu_backward_pkg;
    localparam int DATA_W_DEF = 33;
    localparam int DEPTH_DEF  = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RECORD = 2'd1;
    localparam logic [1:0] ST_REPLAY = 2'd2;
endpackage

// File: rtl/relu_backward_if.sv
// Forward tap, gradient input and masked-gradient output of relu_backward, plus tile status.
interface relu_backward_if
    import relu_backward_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = $clog2(DEPTH_DEF)
);
    logic              fwd_valid;
    logic              fwd_ready;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_last;
    logic              bwd_valid;
    logic              bwd_ready;
    logic [DATA_W-1:0] bwd_grad;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_grad;
    logic              out_last;
    logic [AW:0]       count;
    logic              err;

    modport master (
        output fwd_valid, fwd_data, fwd_last, bwd_valid, bwd_grad, out_ready,
        input  fwd_ready, bwd_ready, out_valid, out_grad, out_last, count, err
    );
    modport slave (
        input  fwd_valid, fwd_data, fwd_last, bwd_valid, bwd_grad, out_ready,
        output fwd_ready, bwd_ready, out_valid, out_grad, out_last, count, err
    );
endinterface

// File: rtl/relu_mask_buf.sv
// DEPTH x 1 mask store: one synchronous write port, one asynchronous read port, no reset.
module relu_mask_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_bit,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_bit
);
    logic [DEPTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_bit;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_bit = mem_q[rd_addr];
endmodule

// File: rtl/relu_backward.sv
// Streaming ReLU gradient: records a pass mask from the forward stream, then gates
// the gradient stream with it in order, one beat per cycle.
module relu_backward
    import relu_backward_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    relu_backward_if.slave bus
);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]        state_q, state_d;
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_grad_q, out_grad_d;
    logic              err_q, err_d;

    logic fwd_acc, bwd_acc, out_hs, full, last_pending, wr_en, rd_bit;

    // count doubles as the write pointer; it never passes DEPTH
    assign full         = (count_q == CNT_FULL);
    assign last_pending = out_valid_q & out_last_q;

    assign bus.fwd_ready = (state_q != ST_REPLAY);
    assign bus.bwd_ready = (state_q == ST_REPLAY) & ~last_pending &
                           (~out_valid_q | bus.out_ready);

    assign fwd_acc = bus.fwd_valid & bus.fwd_ready;
    assign bwd_acc = bus.bwd_valid & bus.bwd_ready;
    assign out_hs  = out_valid_q & bus.out_ready;
    assign wr_en   = fwd_acc & ~full & ~clear;

    relu_mask_buf #(.DEPTH(DEPTH), .AW(AW)) u_mask (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_q[AW-1:0]),
        .wr_bit  (~bus.fwd_data[DATA_W-1]),
        .rd_addr (rd_ptr_q),
        .rd_bit  (rd_bit)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_grad_d  = out_grad_q;
        err_d       = err_q;
        if (clear) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_grad_d  = '0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_RECORD: begin
                    if (fwd_acc) begin
                        if (!full) count_d = count_q + CNT_ONE;
                        else       err_d   = 1'b1;
                        state_d = bus.fwd_last ? ST_REPLAY : ST_RECORD;
                    end
                end
                ST_REPLAY: begin
                    // a new beat reloads the register even while the old one leaves
                    if (bwd_acc) begin
                        out_valid_d = 1'b1;
                        out_grad_d  = rd_bit ? bus.bwd_grad : '0;
                        out_last_d  = ({1'b0, rd_ptr_q} == count_q - CNT_ONE);
                        rd_ptr_d    = rd_ptr_q + PTR_ONE;
                    end else if (out_hs) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                    if (out_hs && last_pending) begin
                        state_d  = ST_IDLE;
                        count_d  = '0;
                        rd_ptr_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_grad_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_grad_q  <= out_grad_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_grad  = out_grad_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_relu_backward.sv
// Bench for relu_backward: randomized tiles checked against a queue-based mask model.
module tb_relu_backward;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    relu_backward_if #(.DATA_W(33), .AW(6)) bus ();
    relu_backward #(.DATA_W(33), .DEPTH(64), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [32:0] fwd_q[$], grad_q[$], exp_q[$], got_g[$];
    bit          got_l[$];

    function automatic logic [32:0] rnd33(input bit pos);
        logic s;
        s = pos ? 1'b0 : 1'($urandom_range(0, 1));
        return {s, 32'($urandom())};
    endfunction

    // Model: a negative activation blocks its gradient; only the first 64 elements are kept.
    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < fwd_q.size() && i < 64; i++)
            exp_q.push_back(fwd_q[i][32] ? 33'h0 : grad_q[i]);
    endtask

    task automatic drive_fwd(input bit last_at_end);
        for (int i = 0; i < fwd_q.size(); i++) begin
            int n = 0;
            @(negedge clk);
            bus.fwd_valid = 1'b1;
            bus.fwd_data  = fwd_q[i];
            bus.fwd_last  = last_at_end && (i == fwd_q.size() - 1);
            #1;
            while (!bus.fwd_ready && n < 50) begin
                @(negedge clk); #1; n++;
            end
            total++;
            if (!bus.fwd_ready) begin
                bad++;
                $display("FAIL fwd_accept_timeout beat=%0d fwd_ready=%b required=1", i, bus.fwd_ready);
            end
            @(posedge clk); #1;
        end
        bus.fwd_valid = 1'b0;
        bus.fwd_last  = 1'b0;
    endtask

    task automatic drive_bwd(input int pct, input int max_out);
        int gi = 0;
        int cyc = 0;
        bit done = 0;
        got_g.delete();
        got_l.delete();
        while (!done && cyc < 3000) begin
            @(negedge clk);
            bus.bwd_valid = (gi < grad_q.size());
            bus.bwd_grad  = (gi < grad_q.size()) ? grad_q[gi] : 33'h0;
            bus.out_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (bus.bwd_valid && bus.bwd_ready) gi++;
            if (bus.out_valid && bus.out_ready) begin
                got_g.push_back(bus.out_grad);
                got_l.push_back(bus.out_last);
                if (bus.out_last || got_g.size() == max_out) done = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.bwd_valid = 1'b0;
        bus.out_ready = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL bwd_timeout outputs=%0d required_done=1", got_g.size());
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    task automatic test_reset();
        bus.fwd_valid = 0; bus.fwd_data = '0; bus.fwd_last = 0;
        bus.bwd_valid = 0; bus.bwd_grad = '0; bus.out_ready = 0;
        rst_n = 1'b0;
        #12;
        total++;
        if ({bus.out_valid, bus.out_last, bus.count, bus.err, bus.fwd_ready, bus.bwd_ready} !== 12'b0_0_0000000_0_1_0) begin
            bad++;
            $display("FAIL reset_state got v=%b l=%b cnt=%0d err=%b fr=%b br=%b required 0 0 0 0 1 0",
                     bus.out_valid, bus.out_last, bus.count, bus.err, bus.fwd_ready, bus.bwd_ready);
        end
        total++;
        if (bus.out_grad !== 33'h0) begin
            bad++; $display("FAIL reset_grad got=%h required=0", bus.out_grad);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        fwd_q = '{33'h0_0000_0005, 33'h1_FFFF_FFFB, 33'h0_0000_0000, 33'h1_0000_0000};
        grad_q = '{33'h11, 33'h22, 33'h33, 33'h44};
        drive_fwd(1);
        total++;
        if (bus.count !== 7'd4 || bus.fwd_ready !== 1'b0 || bus.bwd_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_recorded cnt=%0d fr=%b br=%b required 4 0 1", bus.count, bus.fwd_ready, bus.bwd_ready);
        end
        build_exp();
        drive_bwd(100, 1000);
        total++;
        if (got_g.size() != 4) begin
            bad++; $display("FAIL basic_len got=%0d required=4", got_g.size());
        end
        for (int i = 0; i < got_g.size() && i < 4; i++) begin
            total++;
            if (got_g[i] !== exp_q[i] || got_l[i] !== (i == 3)) begin
                bad++;
                $display("FAIL basic_beat%0d got=%h/%b required=%h/%b", i, got_g[i], got_l[i], exp_q[i], i == 3);
            end
        end
        total++;
        if (bus.count !== 7'd0 || bus.fwd_ready !== 1'b1) begin
            bad++; $display("FAIL basic_idle cnt=%0d fr=%b required 0 1", bus.count, bus.fwd_ready);
        end
    endtask

    task automatic test_backpressure();
        int gi = 0;
        int held = 0;
        int cyc = 0;
        fwd_q = '{33'h0_0000_0005, 33'h1_FFFF_FFFB, 33'h0_0000_0000, 33'h1_0000_0000};
        grad_q = '{33'h11, 33'h22, 33'h33, 33'h44};
        drive_fwd(1);
        build_exp();
        got_g.delete(); got_l.delete();
        while (got_g.size() < 4 && cyc < 200) begin
            @(negedge clk);
            bus.bwd_valid = (gi < 4);
            bus.bwd_grad  = (gi < 4) ? grad_q[gi] : 33'h0;
            bus.out_ready = !(got_g.size() == 1 && held < 3);
            #1;
            if (!bus.out_ready && bus.out_valid) begin
                held++;
                total++;
                if (bus.out_grad !== exp_q[1] || bus.bwd_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_hold%0d grad=%h br=%b required=%h 0", held, bus.out_grad, bus.bwd_ready, exp_q[1]);
                end
            end
            if (bus.bwd_valid && bus.bwd_ready) gi++;
            if (bus.out_valid && bus.out_ready) begin
                got_g.push_back(bus.out_grad);
                got_l.push_back(bus.out_last);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.bwd_valid = 0; bus.out_ready = 0;
        total++;
        if (held != 3 || got_g.size() != 4) begin
            bad++; $display("FAIL bp_counts held=%0d outs=%0d required 3 4", held, got_g.size());
        end
        for (int i = 0; i < got_g.size() && i < 4; i++) begin
            total++;
            if (got_g[i] !== exp_q[i] || got_l[i] !== (i == 3)) begin
                bad++;
                $display("FAIL bp_beat%0d got=%h/%b required=%h/%b", i, got_g[i], got_l[i], exp_q[i], i == 3);
            end
        end
    endtask

    task automatic test_overflow();
        fwd_q.delete(); grad_q.delete();
        for (int i = 0; i < 66; i++) begin
            fwd_q.push_back(rnd33(1));
            grad_q.push_back(rnd33(0));
        end
        drive_fwd(1);
        total++;
        if (bus.count !== 7'd64 || bus.err !== 1'b1) begin
            bad++; $display("FAIL ovf_status cnt=%0d err=%b required 64 1", bus.count, bus.err);
        end
        build_exp();
        drive_bwd(70, 1000);
        total++;
        if (got_g.size() != 64) begin
            bad++; $display("FAIL ovf_len got=%0d required=64", got_g.size());
        end
        for (int i = 0; i < got_g.size() && i < 64; i++) begin
            total++;
            if (got_g[i] !== exp_q[i] || got_l[i] !== (i == 63)) begin
                bad++;
                $display("FAIL ovf_beat%0d got=%h/%b required=%h/%b", i, got_g[i], got_l[i], exp_q[i], i == 63);
            end
        end
        total++;
        if (bus.err !== 1'b1 || bus.count !== 7'd0) begin
            bad++; $display("FAIL ovf_after err=%b cnt=%0d required 1 0", bus.err, bus.count);
        end
    endtask

    task automatic test_single();
        pulse_clear();
        total++;
        if (bus.err !== 1'b0) begin
            bad++; $display("FAIL clear_err got=%b required=0", bus.err);
        end
        fwd_q = '{33'h1_FFFF_FFFF};
        grad_q = '{33'h7};
        drive_fwd(1);
        total++;
        if (bus.fwd_ready !== 1'b0 || bus.bwd_ready !== 1'b1 || bus.count !== 7'd1) begin
            bad++;
            $display("FAIL single_replay fr=%b br=%b cnt=%0d required 0 1 1", bus.fwd_ready, bus.bwd_ready, bus.count);
        end
        build_exp();
        drive_bwd(100, 1000);
        total++;
        if (got_g.size() != 1 || got_g[0] !== exp_q[0] || got_l[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_out n=%0d got=%h required n=1 %h last=1", got_g.size(),
                     (got_g.size() > 0) ? got_g[0] : 33'h0, exp_q[0]);
        end
    endtask

    task automatic test_stall();
        fwd_q.delete(); grad_q.delete();
        for (int i = 0; i < 5; i++) begin
            fwd_q.push_back(rnd33(0));
            grad_q.push_back(rnd33(0));
        end
        bus.bwd_valid = 1'b1;
        bus.bwd_grad  = grad_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.fwd_valid = 1'b1;
            bus.fwd_data  = fwd_q[i];
            bus.fwd_last  = (i == 4);
            #1;
            total++;
            if (bus.bwd_ready !== 1'b0 || bus.fwd_ready !== 1'b1) begin
                bad++; $display("FAIL stall_record%0d br=%b fr=%b required 0 1", i, bus.bwd_ready, bus.fwd_ready);
            end
            @(posedge clk); #1;
        end
        bus.bwd_valid = 1'b0;
        bus.fwd_last  = 1'b0;
        bus.fwd_data  = rnd33(0);
        @(negedge clk); #1;
        total++;
        if (bus.fwd_ready !== 1'b0) begin
            bad++; $display("FAIL stall_replay_fwd fr=%b required=0", bus.fwd_ready);
        end
        @(posedge clk); #1;
        total++;
        if (bus.count !== 7'd5) begin
            bad++; $display("FAIL stall_count got=%0d required=5", bus.count);
        end
        bus.fwd_valid = 1'b0;
        build_exp();
        drive_bwd(50, 1000);
        total++;
        if (got_g.size() != 5) begin
            bad++; $display("FAIL stall_len got=%0d required=5", got_g.size());
        end
        for (int i = 0; i < got_g.size() && i < 5; i++) begin
            total++;
            if (got_g[i] !== exp_q[i]) begin
                bad++; $display("FAIL stall_beat%0d got=%h required=%h", i, got_g[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        fwd_q.delete(); grad_q.delete();
        for (int i = 0; i < 4; i++) begin
            fwd_q.push_back(rnd33(0));
            grad_q.push_back(rnd33(0));
        end
        drive_fwd(1);
        build_exp();
        drive_bwd(100, 2);
        for (int i = 0; i < got_g.size() && i < 2; i++) begin
            total++;
            if (got_g[i] !== exp_q[i]) begin
                bad++; $display("FAIL clear_pre%0d got=%h required=%h", i, got_g[i], exp_q[i]);
            end
        end
        pulse_clear();
        total++;
        if ({bus.out_valid, bus.count, bus.fwd_ready, bus.bwd_ready, bus.err} !== 11'b0_0000000_1_0_0) begin
            bad++;
            $display("FAIL clear_state v=%b cnt=%0d fr=%b br=%b err=%b required 0 0 1 0 0",
                     bus.out_valid, bus.count, bus.fwd_ready, bus.bwd_ready, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            int n = $urandom_range(1, 20);
            fwd_q.delete(); grad_q.delete();
            for (int i = 0; i < n; i++) begin
                fwd_q.push_back(rnd33(0));
                grad_q.push_back(rnd33(0));
            end
            drive_fwd(1);
            build_exp();
            drive_bwd(60, 1000);
            total++;
            if (got_g.size() != n) begin
                bad++; $display("FAIL b2b%0d_len got=%0d required=%0d", t, got_g.size(), n);
            end
            for (int i = 0; i < got_g.size() && i < n; i++) begin
                total++;
                if (got_g[i] !== exp_q[i] || got_l[i] !== (i == n - 1)) begin
                    bad++;
                    $display("FAIL b2b%0d_beat%0d got=%h/%b required=%h/%b", t, i, got_g[i], got_l[i], exp_q[i], i == n - 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        fwd_q.delete();
        for (int i = 0; i < 65; i++) fwd_q.push_back(rnd33(1));
        drive_fwd(0);
        total++;
        if (bus.err !== 1'b1 || bus.count !== 7'd64) begin
            bad++; $display("FAIL rmid_pre err=%b cnt=%0d required 1 64", bus.err, bus.count);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_last, bus.count, bus.err, bus.fwd_ready, bus.bwd_ready} !== 12'b0_0_0000000_0_1_0
            || bus.out_grad !== 33'h0) begin
            bad++;
            $display("FAIL rmid_state v=%b l=%b cnt=%0d err=%b fr=%b br=%b grad=%h required 0 0 0 0 1 0 0",
                     bus.out_valid, bus.out_last, bus.count, bus.err, bus.fwd_ready, bus.bwd_ready, bus.out_grad);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout sim_time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_single();
        test_stall();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Streaming ReLU gradient unit: the backward-pass counterpart of the forward ReLU (B = A when A[32]==0, else 0).
- During the forward pass it records a 1-bit pass mask per element of a DATA_W-bit signed stream. During the backward pass it replays that mask in order over the incoming gradient stream.
- Sits beside the forward ReLU in the accelerator datapath; the forward stream is tapped in parallel.

Parameters:
DATA_W, 33, width of forward activations and gradients (two's complement, MSB = sign)
DEPTH, 64, max elements per recorded tile (mask buffer entries, power of 2)
AW, 6, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: return to IDLE, clear pointers and error
fwd_valid  input  1  forward element valid
fwd_ready  output  1  forward element accepted when valid&ready
fwd_data  input  DATA_W  forward pre-activation value
fwd_last  input  1  marks final forward element of the tile
bwd_valid  input  1  gradient valid
bwd_ready  output  1  gradient accepted when valid&ready
bwd_grad  input  DATA_W  upstream gradient
out_valid  output  1  masked gradient valid
out_ready  input  1  downstream ready
out_grad  output  DATA_W  masked gradient
out_last  output  1  final gradient of the tile
count  output  AW+1  elements recorded in the current tile
err  output  1  sticky: forward overflow (more than DEPTH elements)

Behaviour:
- Reset (rst_n low, async): state=IDLE, wr_ptr=rd_ptr=0, count=0, out_valid=0, out_grad=0, out_last=0, err=0. Mask contents need no reset.
- Mask rule: mask = ~fwd_data[DATA_W-1]. This matches the forward select exactly, so zero passes.
- out_grad = mask ? bwd_grad : 0. No arithmetic and no width change.
- IDLE: fwd_ready=1, bwd_ready=0. A forward accept writes mask[0], sets wr_ptr=1 and count=1.
  - Next state is REPLAY if fwd_last, else RECORD.
- RECORD: fwd_ready=1, bwd_ready=0. Each accept writes mask[wr_ptr] and increments wr_ptr and count while count<DEPTH.
  - At count==DEPTH, further beats are accepted but dropped, and err is set (sticky).
  - An accept with fwd_last moves to REPLAY; a dropped last still ends the tile.
- REPLAY: fwd_ready=0, bwd_ready = !out_valid | out_ready.
  - Each bwd accept registers out_grad from mask[rd_ptr], sets out_valid=1 and out_last=(rd_ptr==count-1), then increments rd_ptr.
  - Latency is 1 cycle from bwd accept to out_valid. Full throughput is 1 beat/cycle under continuous out_ready.
- Output hold: out_valid and out_grad stay stable until out_ready.
  - out_valid clears on out_ready when no new beat is accepted the same cycle.
  - Simultaneous out_ready and bwd accept reloads the output with no bubble.
- Tile end: after accepting the bwd beat with rd_ptr==count-1, bwd_ready=0. The state moves to IDLE once that last output is handshaken.
  - wr_ptr, rd_ptr and count return to 0; err is retained.
- clear (sync, highest priority after reset): same effect as reset except the mask is untouched. Any pending output is discarded.
- bwd beats presented outside REPLAY are stalled (bwd_ready=0), never dropped. fwd beats in REPLAY are stalled likewise.
- Reset mid-tile: all progress lost; the host must re-run the forward tile.

Decomposition:
- Shared package: DATA_W and DEPTH defaults, and the state encoding (IDLE=2'd0, RECORD=2'd1, REPLAY=2'd2).
- One natural sub-module, relu_mask_buf: DEPTH x 1 register file with one write port (wr_en, wr_addr, wr_bit) and one async read port. The FSM, pointers and output register stay in relu_backward.

Test Plan:
- Forward 4 beats: 0x0_0000_0005, 0x1_FFFF_FFFB (-5), 0x0_0000_0000, 0x1_0000_0000 (last). Then grads 0x11, 0x22, 0x33, 0x44 with out_ready=1 -> outputs 0x11, 0x0, 0x33, 0x0; out_last only on the 4th; back in IDLE; count=0.
- Backpressure: same tile, out_ready low for 3 cycles on beat 2 -> out_grad held at 0x0 with out_valid=1, bwd_ready=0; no loss or duplication; order preserved.
- Overflow: 66 forward beats, all positive, last on the 66th -> count=64, err=1. Replay emits exactly 64 gradients, out_last on the 64th.
- Single-element tile with fwd_last on first beat (value -1) -> REPLAY immediately; grad 0x7 -> out 0x0 with out_last=1.
- Stall rules: bwd_valid asserted during RECORD -> bwd_ready=0 until REPLAY; fwd_valid in REPLAY -> fwd_ready=0.
- Abort: clear pulsed mid-REPLAY after 2 of 4 outputs -> out_valid=0 next cycle, IDLE, count=0. Async rst_n drop mid-RECORD -> all outputs at reset values, err=0.
